// File: rtl/axi_wr_slave.sv
// AXI4 write-channel slave: one outstanding burst, FIXED/INCR/WRAP addressing, streamed to a memory write port.
// Optional macro AXI_WR_SLAVE_WLAST_CHECK_EN flags a wlast that disagrees with the beat count as a slave error.
module axi_wr_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_WIDTH-1:0]   axi_awid,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr,
    input  logic [7:0]            axi_awlen,
    input  logic [2:0]            axi_awsize,
    input  logic [1:0]            axi_awburst,
    input  logic                  axi_awvalid,
    output logic                  axi_awready,
    input  logic [DATA_WIDTH-1:0] axi_wdata,
    input  logic [STRB_WIDTH-1:0] axi_wstrb,
    input  logic                  axi_wlast,
    input  logic                  axi_wvalid,
    output logic                  axi_wready,
    output logic [ID_WIDTH-1:0]   axi_bid,
    output logic [1:0]            axi_bresp,
    output logic                  axi_bvalid,
    input  logic                  axi_bready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [STRB_WIDTH-1:0] mem_wr_strb
);

    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_WIDTH));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] wrap_mask_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  last_beat;
    logic                  aw_err;
    logic                  beat_err;
    logic [ADDR_WIDTH-1:0] aw_wrap_mask;
    logic [ADDR_WIDTH-1:0] beat_incr;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Handshake readies come from state alone, so no input reaches a ready combinationally.
    assign axi_awready = (state_q == ST_IDLE);
    assign axi_wready  = (state_q == ST_DATA);
    assign axi_bvalid  = (state_q == ST_RESP);
    assign axi_bid     = id_q;
    assign axi_bresp   = err_q ? 2'b10 : 2'b00;

    assign aw_hs     = axi_awvalid && axi_awready;
    assign w_hs      = axi_wvalid && axi_wready;
    assign b_hs      = axi_bvalid && axi_bready;
    assign last_beat = (cnt_q == len_q);

    assign aw_err = (axi_awburst == 2'b11)
                 || (axi_awsize > SIZE_MAX)
                 || ((axi_awburst == 2'b10) &&
                     !((axi_awlen == 8'd1) || (axi_awlen == 8'd3) ||
                       (axi_awlen == 8'd7) || (axi_awlen == 8'd15)));

    // Wrap window is (len+1) beats of (1<<size) bytes; only meaningful for legal WRAP lengths.
    assign aw_wrap_mask = ((ADDR_WIDTH'(axi_awlen) + ADDR_WIDTH'(1)) << axi_awsize) - ADDR_WIDTH'(1);
    assign beat_incr    = ADDR_WIDTH'(1) << size_q;

`ifdef AXI_WR_SLAVE_WLAST_CHECK_EN
    assign beat_err = (axi_wlast != last_beat);
`else
    logic unused_wlast;
    assign unused_wlast = axi_wlast;
    assign beat_err     = 1'b0;
`endif

    always_comb begin
        case (burst_q)
            2'b00:   addr_next = addr_q;
            2'b10:   addr_next = (addr_q & ~wrap_mask_q) | ((addr_q + beat_incr) & wrap_mask_q);
            default: addr_next = addr_q + beat_incr;
        endcase
    end

    assign mem_wr_en   = w_hs && !err_q && !beat_err;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = axi_wdata;
    assign mem_wr_strb = axi_wstrb;

    always_comb begin
        // NOTE: next state defaults to the current state first so no path through this block infers a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (aw_hs)             state_d = ST_DATA;
            ST_DATA: if (w_hs && last_beat) state_d = ST_RESP;
            ST_RESP: if (b_hs)              state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            // NOTE: the AW context is reset too, so bid reads 0 after reset rather than a stale id.
            state_q     <= ST_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            wrap_mask_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q        <= axi_awid;
                addr_q      <= axi_awaddr;
                wrap_mask_q <= aw_wrap_mask;
                len_q       <= axi_awlen;
                size_q      <= axi_awsize;
                burst_q     <= axi_awburst;
                cnt_q       <= '0;
                err_q       <= aw_err;
            end else if (w_hs) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= addr_next;
                if (beat_err) err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed scenarios plus randomized bursts against an arithmetic address model.
// Expectations follow AXI_WR_SLAVE_WLAST_CHECK_EN when the macro is defined for the build.
module tb_axi_wr_slave;

    logic        aclk;
    logic        areset;
    logic [7:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [7:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;

    int vectors;
    int miscompares;

`ifdef AXI_WR_SLAVE_WLAST_CHECK_EN
    localparam bit WLAST_CHK = 1'b1;
`else
    localparam bit WLAST_CHK = 1'b0;
`endif

    axi_wr_slave dut (
        .aclk        (aclk),
        .areset      (areset),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (axi_awsize),
        .axi_awburst (axi_awburst),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_strb (mem_wr_strb)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Address of beat i from the burst rules: byte offset i*(1<<size), wrapped inside an aligned window for WRAP.
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len, input int size,
                                              input int burst, input int i);
        logic [31:0] bytes, total, base;
        bytes = 32'd1 << size;
        case (burst)
            0: return start;
            2: begin
                total = 32'(len + 1) * bytes;
                base  = start - (start % total);
                return base + (((start - base) + 32'(i) * bytes) % total);
            end
            default: return start + 32'(i) * bytes;
        endcase
    endfunction

    // One burst. bad_beat inverts wlast on that beat (-1: none); abort_at applies reset once that many beats are in.
    task automatic run_txn(input logic [7:0] id, input logic [31:0] addr, input int len, input int size,
                           input int burst, input int bad_beat, input int bready_delay,
                           input int abort_at, input int gap_pct);
        bit          aw_err;
        int          err_at;
        logic [1:0]  exp_resp;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          i;
        aw_err = (burst == 3) || (size > 2) ||
                 ((burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
        if (aw_err) err_at = 0;
        else if (WLAST_CHK && bad_beat >= 0) err_at = bad_beat;
        else err_at = len + 1;
        exp_resp = (aw_err || (WLAST_CHK && bad_beat >= 0 && bad_beat <= len)) ? 2'b10 : 2'b00;

        @(posedge aclk); #1;
        axi_awid    = id;
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        axi_awsize  = 3'(size);
        axi_awburst = 2'(burst);
        axi_awvalid = 1'b1;
        @(negedge aclk);
        check("aw_awready", 64'(axi_awready), 64'd1);
        check("aw_wready",  64'(axi_wready),  64'd0);
        check("aw_bvalid",  64'(axi_bvalid),  64'd0);
        @(posedge aclk); #1;
        axi_awvalid = 1'b0;
        axi_awaddr  = $urandom;

        i = 0;
        while (i <= len) begin
            wd = $urandom;
            ws = 4'($urandom);
            axi_wvalid = ($urandom_range(0, 99) >= gap_pct);
            axi_wdata  = wd;
            axi_wstrb  = ws;
            axi_wlast  = (i == len) ^ (i == bad_beat);
            @(negedge aclk);
            check("w_wready",  64'(axi_wready),  64'd1);
            check("w_awready", 64'(axi_awready), 64'd0);
            check("w_bvalid",  64'(axi_bvalid),  64'd0);
            if (axi_wvalid) begin
                check("w_en", 64'(mem_wr_en), 64'(i < err_at));
                if (i < err_at) begin
                    check("w_addr", 64'(mem_wr_addr), 64'(beat_addr(addr, len, size, burst, i)));
                    check("w_data", 64'(mem_wr_data), 64'(wd));
                    check("w_strb", 64'(mem_wr_strb), 64'(ws));
                end
            end else begin
                check("w_idle_en", 64'(mem_wr_en), 64'd0);
            end
            @(posedge aclk); #1;
            if (axi_wvalid) i++;
            axi_wvalid = 1'b0;
            axi_wlast  = 1'b0;
            if (i == abort_at) begin
                areset = 1'b1;
                @(posedge aclk); #1;
                areset = 1'b0;
                @(negedge aclk);
                check("rst_awready", 64'(axi_awready), 64'd1);
                check("rst_wready",  64'(axi_wready),  64'd0);
                check("rst_bvalid",  64'(axi_bvalid),  64'd0);
                check("rst_bresp",   64'(axi_bresp),   64'd0);
                check("rst_bid",     64'(axi_bid),     64'd0);
                check("rst_en",      64'(mem_wr_en),   64'd0);
                return;
            end
        end

        axi_bready = 1'b0;
        repeat (bready_delay) begin
            @(negedge aclk);
            check("b_hold_bvalid", 64'(axi_bvalid), 64'd1);
            check("b_hold_bid",    64'(axi_bid),    64'(id));
            check("b_hold_bresp",  64'(axi_bresp),  64'(exp_resp));
            check("b_hold_wready", 64'(axi_wready), 64'd0);
            @(posedge aclk); #1;
        end
        axi_bready = 1'b1;
        @(negedge aclk);
        check("b_bvalid",  64'(axi_bvalid),  64'd1);
        check("b_bid",     64'(axi_bid),     64'(id));
        check("b_bresp",   64'(axi_bresp),   64'(exp_resp));
        check("b_awready", 64'(axi_awready), 64'd0);
        @(posedge aclk); #1;
        axi_bready = 1'b0;
        @(negedge aclk);
        check("post_b_awready", 64'(axi_awready), 64'd1);
        check("post_b_bvalid",  64'(axi_bvalid),  64'd0);
    endtask

    initial begin
        int len, size, burst, bad;
        vectors     = 0;
        miscompares = 0;
        areset      = 1'b1;
        axi_awid    = '0;
        axi_awaddr  = '0;
        axi_awlen   = '0;
        axi_awsize  = '0;
        axi_awburst = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wlast   = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check("reset_awready", 64'(axi_awready), 64'd1);
        check("reset_wready",  64'(axi_wready),  64'd0);
        check("reset_bvalid",  64'(axi_bvalid),  64'd0);
        check("reset_bresp",   64'(axi_bresp),   64'd0);
        check("reset_bid",     64'(axi_bid),     64'd0);
        check("reset_en",      64'(mem_wr_en),   64'd0);

        // INCR 0x100, four words, OKAY
        run_txn(8'h5A, 32'h100, 3, 2, 1, -1, 0, -1, 0);
        // WRAP 0x108 within a 16-byte window
        run_txn(8'h33, 32'h108, 3, 2, 2, -1, 0, -1, 0);
        // Reserved burst type: beats accepted, nothing written, SLVERR
        run_txn(8'h11, 32'h200, 1, 2, 3, -1, 0, -1, 0);
        // bready held low for five cycles
        run_txn(8'hC3, 32'h40, 1, 2, 1, -1, 5, -1, 0);
        // wlast asserted early on beat 1
        run_txn(8'h77, 32'h300, 3, 2, 1, 1, 0, -1, 0);
        // Oversized beat and illegal WRAP length both error
        run_txn(8'h01, 32'h400, 1, 3, 1, -1, 0, -1, 0);
        run_txn(8'h02, 32'h500, 2, 2, 2, -1, 0, -1, 0);
        // FIXED and address wrap-around at the top of the address space
        run_txn(8'h03, 32'h80, 2, 1, 0, -1, 1, -1, 0);
        run_txn(8'h04, 32'hFFFF_FFF8, 3, 2, 1, -1, 0, -1, 0);
        // Reset after beat 1 of a len=7 burst, then a single-beat INCR
        run_txn(8'h9E, 32'h600, 7, 2, 1, -1, 0, 2, 0);
        run_txn(8'h9F, 32'h700, 0, 2, 1, -1, 0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            burst = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
            size  = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0: len = 1;
                1: len = 3;
                2: len = 7;
                default: len = 15;
            endcase
            if ($urandom_range(0, 4) == 0) len = $urandom_range(0, 15);
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
            run_txn(8'($urandom), $urandom, len, size, burst, bad, $urandom_range(0, 3), -1, 25);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
